// File: rtl/seq_det_prog.sv
// Programmable serial sequence detector: runtime-loadable 1..MAX_LEN bit pattern,
// overlapping or non-overlapping matching, valid-qualified input and saturating match counter.
module seq_det_prog #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = 8'b0001_0110,
    parameter int                 DEF_LEN     = 5,
    parameter bit                 DEF_OVERLAP = 1'b1,
    localparam int                LEN_W       = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in,
    input  logic               in_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               cnt_clr,
    output logic               out,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               cfg_err
);

    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   vcnt_q, vcnt_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic               out_q, out_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;

    logic               accept;
    logic               hit;
    logic [MAX_LEN-1:0] hist_shift;
    logic [MAX_LEN-1:0] len_mask;
    logic [LEN_W-1:0]   vcnt_inc;

    always_comb begin
        accept     = in_valid && !cfg_load && !err_q;
        hist_shift = {hist_q[MAX_LEN-2:0], in};
        vcnt_inc   = (vcnt_q == LEN_W'(MAX_LEN)) ? vcnt_q : vcnt_q + LEN_W'(1);
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (i < 32'(len_q));
        end
        // Match is judged on the post-shift history and post-increment fresh count.
        hit = accept && (((hist_shift ^ pat_q) & len_mask) == '0) && (vcnt_inc >= len_q);

        hist_d = hist_q;
        vcnt_d = vcnt_q;
        pat_d  = pat_q;
        len_d  = len_q;
        ovl_d  = ovl_q;
        err_d  = err_q;
        out_d  = hit;
        cnt_d  = cnt_q;

        if (cfg_load) begin
            pat_d  = cfg_pattern;
            len_d  = cfg_len;
            ovl_d  = cfg_overlap;
            hist_d = '0;
            vcnt_d = '0;
            err_d  = (cfg_len == '0) || (cfg_len > LEN_W'(MAX_LEN));
        end else if (accept) begin
            hist_d = hist_shift;
            vcnt_d = (hit && !ovl_q) ? '0 : vcnt_inc;
        end

        if (cnt_clr || cfg_load) begin
            cnt_d = '0;
        end else if (hit && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hist_q <= '0;
            vcnt_q <= '0;
            pat_q  <= DEF_PATTERN;
            len_q  <= LEN_W'(DEF_LEN);
            ovl_q  <= DEF_OVERLAP;
            out_q  <= 1'b0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            hist_q <= hist_d;
            vcnt_q <= vcnt_d;
            pat_q  <= pat_d;
            len_q  <= len_d;
            ovl_q  <= ovl_d;
            out_q  <= out_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    assign out       = out_q;
    assign match_cnt = cnt_q;
    assign cfg_err   = err_q;

endmodule

// File: tb/tb_seq_det_prog.sv
// Scoreboard bench for seq_det_prog: a default instance plus a CNT_W=2 instance for saturation.
module tb_seq_det_prog;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    logic               clk = 1'b0;
    logic               rst;
    logic               din;
    logic               in_valid;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               cnt_clr;
    logic               out;
    logic [7:0]         match_cnt;
    logic               cfg_err;
    logic               out2;
    logic [1:0]         match_cnt2;
    logic               cfg_err2;

    int n_chk  = 0;
    int n_fail = 0;

    bit exp_q[$];
    int cnt_q[$];

    always #5 clk = ~clk;

    seq_det_prog dut (
        .clk(clk), .rst(rst), .in(din), .in_valid(in_valid), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .cnt_clr(cnt_clr), .out(out), .match_cnt(match_cnt), .cfg_err(cfg_err)
    );

    seq_det_prog #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in(din), .in_valid(in_valid), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .cnt_clr(cnt_clr), .out(out2), .match_cnt(match_cnt2), .cfg_err(cfg_err2)
    );

    // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
    task automatic step(input bit b, input bit v);
        din      = b;
        in_valid = v;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        step(1'b0, 1'b0);
        rst = 1'b1;
    endtask

    task automatic load_cfg(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l, input bit o);
        cfg_pattern = p;
        cfg_len     = l;
        cfg_overlap = o;
        cfg_load    = 1'b1;
        step(1'b1, 1'b1);
        cfg_load    = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_chk++;
        if (out !== 1'b0 || match_cnt !== 8'd0 || cfg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: out=%b cnt=%0d err=%b, want 0/0/0", out, match_cnt, cfg_err);
        end
        n_chk++;
        if (out2 !== 1'b0 || match_cnt2 !== 2'd0) begin
            n_fail++;
            $display("FAIL reset2: out=%b cnt=%0d, want 0/0", out2, match_cnt2);
        end
    endtask

    task automatic test_default();
        logic [4:0] s;
        bit e;
        s = 5'b10110;
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(i == 4);
            if (i < 5) step(s[4-i], 1'b1);
            else       step(1'b0, 1'b0);
            e = exp_q.pop_front();
            n_chk++;
            if (out !== e) begin
                n_fail++;
                $display("FAIL default_out[%0d]: got %b want %b", i, out, e);
            end
        end
        n_chk++;
        if (match_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL default_cnt: got %0d want 1", match_cnt);
        end
    endtask

    task automatic test_overlap();
        logic [7:0] s;
        bit e;
        s = 8'b10110110;
        for (int mode = 0; mode < 2; mode++) begin
            apply_reset();
            if (mode == 1) load_cfg(8'b0001_0110, 4'd5, 1'b0);
            for (int i = 0; i < 8; i++) begin
                exp_q.push_back(i == 4 || (mode == 0 && i == 7));
                step(s[7-i], 1'b1);
                e = exp_q.pop_front();
                n_chk++;
                if (out !== e) begin
                    n_fail++;
                    $display("FAIL overlap_out[mode%0d bit%0d]: got %b want %b", mode, i, out, e);
                end
            end
            n_chk++;
            if (match_cnt !== ((mode == 0) ? 8'd2 : 8'd1)) begin
                n_fail++;
                $display("FAIL overlap_cnt[mode%0d]: got %0d want %0d", mode, match_cnt, (mode == 0) ? 2 : 1);
            end
        end
    endtask

    task automatic test_valid_gaps();
        logic [4:0] s;
        int gaps[5];
        bit e;
        s = 5'b10110;
        gaps = '{0, 1, 2, 3, 1};
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            for (int g = 0; g < gaps[i]; g++) begin
                exp_q.push_back(1'b0);
                step(1'b1, 1'b0);
                e = exp_q.pop_front();
                n_chk++;
                if (out !== e) begin
                    n_fail++;
                    $display("FAIL gap_out[bit%0d gap%0d]: got %b want %b", i, g, out, e);
                end
            end
            exp_q.push_back(i == 4);
            step(s[4-i], 1'b1);
            e = exp_q.pop_front();
            n_chk++;
            if (out !== e) begin
                n_fail++;
                $display("FAIL gap_out[bit%0d]: got %b want %b", i, out, e);
            end
        end
        n_chk++;
        if (match_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL gap_cnt: got %0d want 1", match_cnt);
        end
    endtask

    task automatic test_reconfig();
        bit e;
        for (int o = 1; o >= 0; o--) begin
            load_cfg(8'b0000_0111, 4'd3, o[0]);
            for (int i = 0; i < 5; i++) begin
                exp_q.push_back(i == 2 || (o == 1 && i > 2));
                step(1'b1, 1'b1);
                e = exp_q.pop_front();
                n_chk++;
                if (out !== e) begin
                    n_fail++;
                    $display("FAIL reconf_out[ovl%0d bit%0d]: got %b want %b", o, i, out, e);
                end
            end
            n_chk++;
            if (match_cnt !== ((o == 1) ? 8'd3 : 8'd1)) begin
                n_fail++;
                $display("FAIL reconf_cnt[ovl%0d]: got %0d want %0d", o, match_cnt, (o == 1) ? 3 : 1);
            end
        end
        load_cfg(8'b0000_0000, 4'd0, 1'b1);
        n_chk++;
        if (cfg_err !== 1'b1) begin
            n_fail++;
            $display("FAIL cfg_err_len0: got %b want 1", cfg_err);
        end
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(1'b0);
            step((i < 5) ? 1'b1 : ~i[0], 1'b1);
            e = exp_q.pop_front();
            n_chk++;
            if (out !== e) begin
                n_fail++;
                $display("FAIL err_out[%0d]: got %b want %b", i, out, e);
            end
        end
        n_chk++;
        if (match_cnt !== 8'd0 || cfg_err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_hold: cnt=%0d err=%b, want 0/1", match_cnt, cfg_err);
        end
    endtask

    task automatic test_saturation();
        bit e;
        int c;
        int model_cnt;
        apply_reset();
        load_cfg(8'b0000_0111, 4'd3, 1'b1);
        model_cnt = 0;
        for (int i = 0; i < 7; i++) begin
            if (i >= 2 && model_cnt < 3) model_cnt++;
            exp_q.push_back(i >= 2);
            cnt_q.push_back(model_cnt);
            step(1'b1, 1'b1);
            e = exp_q.pop_front();
            c = cnt_q.pop_front();
            n_chk++;
            if (out2 !== e || match_cnt2 !== c[1:0]) begin
                n_fail++;
                $display("FAIL sat[%0d]: out=%b cnt=%0d, want %b/%0d", i, out2, match_cnt2, e, c);
            end
        end
        n_chk++;
        if (match_cnt !== 8'd5) begin
            n_fail++;
            $display("FAIL sat_wide_cnt: got %0d want 5", match_cnt);
        end
        cnt_clr = 1'b1;
        exp_q.push_back(1'b1);
        cnt_q.push_back(0);
        step(1'b1, 1'b1);
        cnt_clr = 1'b0;
        e = exp_q.pop_front();
        c = cnt_q.pop_front();
        n_chk++;
        if (out2 !== e || match_cnt2 !== c[1:0] || match_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL clr_vs_match: out=%b cnt2=%0d cnt=%0d, want 1/0/0", out2, match_cnt2, match_cnt);
        end
    endtask

    task automatic test_reset_mid();
        logic [4:0] pre;
        logic [6:0] post;
        bit e;
        pre  = 5'b10100;
        post = 7'b1010110;
        load_cfg(8'b0000_0111, 4'd3, 1'b0);
        apply_reset();
        for (int i = 0; i < 3; i++) step(pre[4-i], 1'b1);
        // Reset edge with a valid bit and pending cfg_load / cnt_clr: reset wins.
        rst         = 1'b0;
        cfg_pattern = 8'b0000_0011;
        cfg_len     = 4'd2;
        cfg_load    = 1'b1;
        cnt_clr     = 1'b1;
        step(1'b1, 1'b1);
        rst      = 1'b1;
        cfg_load = 1'b0;
        cnt_clr  = 1'b0;
        n_chk++;
        if (out !== 1'b0 || match_cnt !== 8'd0 || cfg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_state: out=%b cnt=%0d err=%b, want 0/0/0", out, match_cnt, cfg_err);
        end
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back(i == 6);
            step(post[6-i], 1'b1);
            e = exp_q.pop_front();
            n_chk++;
            if (out !== e) begin
                n_fail++;
                $display("FAIL midreset_out[%0d]: got %b want %b", i, out, e);
            end
        end
        n_chk++;
        if (match_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL midreset_cnt: got %0d want 1", match_cnt);
        end
    endtask

    initial begin
        rst         = 1'b0;
        din         = 1'b0;
        in_valid    = 1'b0;
        cfg_load    = 1'b0;
        cfg_pattern = '0;
        cfg_len     = '0;
        cfg_overlap = 1'b0;
        cnt_clr     = 1'b0;
        #1;
        step(1'b0, 1'b0);
        test_reset();
        test_default();
        test_overlap();
        test_valid_gaps();
        test_reconfig();
        test_saturation();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
